ldm_stm_sequencer: RTL and testbench

//  Initiator side of the register-file port protocol: walks an LDM/STM 16-bit register list,
//  one memory transfer per listed register. Loads drive the RF write port; stores read via RF port C.

---
 rtl/ldm_stm_sequencer.sv | 133 +++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks a register list, issuing one memory transfer per
// listed register, and drives the register-file read-C / write ports plus optional base writeback.
module ldm_stm_sequencer #(
    parameter int DBUSLEN = 32,
    parameter int ADDRLEN = 4,
    parameter int LISTLEN = 16
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               Seq_Start,
    input  logic               Seq_Is_Load,
    input  logic               Seq_Up,
    input  logic               Seq_Pre,
    input  logic               Seq_Writeback,
    input  logic [ADDRLEN-1:0] Seq_Base_Reg,
    input  logic [DBUSLEN-1:0] Seq_Base_Addr,
    input  logic [LISTLEN-1:0] Seq_Reg_List,
    input  logic               Mem_Ack,
    input  logic [DBUSLEN-1:0] Mem_Rdata,
    input  logic [DBUSLEN-1:0] RF_Bus_C,
    output logic               Seq_Busy,
    output logic               Seq_Done,
    output logic               Mem_Req,
    output logic               Mem_Write,
    output logic [DBUSLEN-1:0] Mem_Addr,
    output logic [DBUSLEN-1:0] Mem_Wdata,
    output logic [ADDRLEN-1:0] RF_Addr_C,
    output logic [ADDRLEN-1:0] RF_Addr_Write,
    output logic [DBUSLEN-1:0] RF_Bus_Write,
    output logic               RF_Load_Write
);
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

    state_t             state_q;
    logic               load_q;
    logic               wb_q;
    logic [ADDRLEN-1:0] base_reg_q;
    logic [LISTLEN-1:0] list_q;
    logic [DBUSLEN-1:0] addr_q;
    logic [DBUSLEN-1:0] final_q;

    logic [DBUSLEN-1:0] n_words;
    logic [DBUSLEN-1:0] span;
    logic [DBUSLEN-1:0] start_addr_d;
    logic [DBUSLEN-1:0] final_addr_d;
    logic [ADDRLEN-1:0] cur;
    logic               last_xfer;
    logic               in_xfer;
    logic               in_wb;
    logic               is_store;
    logic               ld_wr;

    always_comb begin
        n_words = '0;
        for (int i = 0; i < LISTLEN; i++) begin
            n_words = n_words + DBUSLEN'(Seq_Reg_List[i]);
        end
        span = n_words << 2;
        unique case ({Seq_Up, Seq_Pre})
            2'b10:   start_addr_d = Seq_Base_Addr;
            2'b11:   start_addr_d = Seq_Base_Addr + DBUSLEN'(4);
            2'b00:   start_addr_d = Seq_Base_Addr - span + DBUSLEN'(4);
            default: start_addr_d = Seq_Base_Addr - span;
        endcase
        final_addr_d = Seq_Up ? (Seq_Base_Addr + span) : (Seq_Base_Addr - span);
    end

    // Lowest remaining register goes first so registers map to ascending addresses.
    always_comb begin
        cur = '0;
        for (int i = LISTLEN - 1; i >= 0; i--) begin
            if (list_q[i]) begin
                cur = ADDRLEN'(i);
            end
        end
    end

    assign last_xfer = ((list_q & (list_q - LISTLEN'(1))) == '0);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            load_q     <= 1'b0;
            wb_q       <= 1'b0;
            base_reg_q <= '0;
            list_q     <= '0;
            addr_q     <= '0;
            final_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Seq_Start) begin
                        load_q     <= Seq_Is_Load;
                        base_reg_q <= Seq_Base_Reg;
                        list_q     <= Seq_Reg_List;
                        addr_q     <= start_addr_d;
                        final_q    <= final_addr_d;
                        // A load that overwrites the base register wins over writeback.
                        wb_q       <= Seq_Writeback && !(Seq_Is_Load && Seq_Reg_List[Seq_Base_Reg]);
                        state_q    <= (Seq_Reg_List == '0) ? S_DONE : S_XFER;
                    end
                end
                S_XFER: begin
                    if (Mem_Ack) begin
                        list_q <= list_q & (list_q - LISTLEN'(1));
                        addr_q <= addr_q + DBUSLEN'(4);
                        if (last_xfer) begin
                            state_q <= wb_q ? S_WB : S_DONE;
                        end
                    end
                end
                S_WB:    state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_xfer  = (state_q == S_XFER);
    assign in_wb    = (state_q == S_WB);
    assign is_store = in_xfer && !load_q;
    assign ld_wr    = in_xfer && load_q && Mem_Ack;

    assign Seq_Busy      = (state_q != S_IDLE);
    assign Seq_Done      = (state_q == S_DONE);
    assign Mem_Req       = in_xfer;
    assign Mem_Write     = is_store;
    assign Mem_Addr      = in_xfer ? {addr_q[DBUSLEN-1:2], 2'b00} : '0;
    assign RF_Addr_C     = is_store ? cur : '0;
    assign Mem_Wdata     = is_store ? RF_Bus_C : '0;
    assign RF_Load_Write = ld_wr || in_wb;
    assign RF_Addr_Write = ld_wr ? cur : (in_wb ? base_reg_q : '0);
    assign RF_Bus_Write  = ld_wr ? Mem_Rdata : (in_wb ? final_q : '0);
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomized bench for ldm_stm_sequencer: each sequence is predicted as a list of
// (address, register) transfers plus an optional writeback, then checked cycle by cycle.
module tb_ldm_stm_sequencer;
    logic        sysclk;
    logic        reset;
    logic        Seq_Start;
    logic        Seq_Is_Load;
    logic        Seq_Up;
    logic        Seq_Pre;
    logic        Seq_Writeback;
    logic [3:0]  Seq_Base_Reg;
    logic [31:0] Seq_Base_Addr;
    logic [15:0] Seq_Reg_List;
    logic        Mem_Ack;
    logic [31:0] Mem_Rdata;
    logic [31:0] RF_Bus_C;
    logic        Seq_Busy;
    logic        Seq_Done;
    logic        Mem_Req;
    logic        Mem_Write;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic [3:0]  RF_Addr_C;
    logic [3:0]  RF_Addr_Write;
    logic [31:0] RF_Bus_Write;
    logic        RF_Load_Write;

    logic [31:0] rf [16];
    int checks = 0;
    int errors = 0;

    ldm_stm_sequencer dut (
        .sysclk(sysclk), .reset(reset), .Seq_Start(Seq_Start), .Seq_Is_Load(Seq_Is_Load),
        .Seq_Up(Seq_Up), .Seq_Pre(Seq_Pre), .Seq_Writeback(Seq_Writeback),
        .Seq_Base_Reg(Seq_Base_Reg), .Seq_Base_Addr(Seq_Base_Addr), .Seq_Reg_List(Seq_Reg_List),
        .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata), .RF_Bus_C(RF_Bus_C),
        .Seq_Busy(Seq_Busy), .Seq_Done(Seq_Done), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write),
        .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata), .RF_Addr_C(RF_Addr_C),
        .RF_Addr_Write(RF_Addr_Write), .RF_Bus_Write(RF_Bus_Write), .RF_Load_Write(RF_Load_Write)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Register file read port C is combinational in its address.
    assign RF_Bus_C = rf[RF_Addr_C];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic scramble_seq_inputs();
        Seq_Start     = 1'($urandom_range(0, 1));
        Seq_Is_Load   = 1'($urandom_range(0, 1));
        Seq_Up        = 1'($urandom_range(0, 1));
        Seq_Pre       = 1'($urandom_range(0, 1));
        Seq_Writeback = 1'($urandom_range(0, 1));
        Seq_Base_Reg  = 4'($urandom);
        Seq_Base_Addr = $urandom;
        Seq_Reg_List  = 16'($urandom);
    endtask

    // Entered just after a falling edge with the DUT idle; returns in the first idle cycle afterwards.
    task automatic run_seq(input logic ld, input logic up, input logic pre, input logic wb,
                           input logic [3:0] breg, input logic [31:0] base, input logic [15:0] list,
                           input bit full_ack);
        int unsigned n;
        logic [3:0]  regs[$];
        logic [31:0] addr;
        logic [31:0] fin;
        bit          wb_exp;
        int          idx;
        int          waits;
        logic        ack;

        regs.delete();
        for (int r = 0; r < 16; r++) if (list[r]) regs.push_back(4'(r));
        n = regs.size();
        case ({up, pre})
            2'b10:   addr = base;
            2'b11:   addr = base + 32'd4;
            2'b00:   addr = base - 32'(4 * n) + 32'd4;
            default: addr = base - 32'(4 * n);
        endcase
        fin    = up ? base + 32'(4 * n) : base - 32'(4 * n);
        wb_exp = wb && (n != 0) && !(ld && list[breg]);
        rf[breg] = base;

        Seq_Start = 1'b1; Seq_Is_Load = ld; Seq_Up = up; Seq_Pre = pre; Seq_Writeback = wb;
        Seq_Base_Reg = breg; Seq_Base_Addr = base; Seq_Reg_List = list; Mem_Ack = 1'b0;
        #1;
        check_eq("idle_busy", 32'(Seq_Busy), 32'd0);
        check_eq("idle_req", 32'(Mem_Req), 32'd0);
        @(negedge sysclk);

        idx = 0;
        waits = 0;
        while (idx < int'(n)) begin
            scramble_seq_inputs();
            ack = (full_ack || waits >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            Mem_Ack = ack;
            Mem_Rdata = $urandom;
            #1;
            check_eq("xfer_busy", 32'(Seq_Busy), 32'd1);
            check_eq("xfer_done", 32'(Seq_Done), 32'd0);
            check_eq("xfer_req", 32'(Mem_Req), 32'd1);
            check_eq("xfer_write", 32'(Mem_Write), 32'(!ld));
            check_eq("xfer_addr", Mem_Addr, addr & ~32'd3);
            if (!ld) begin
                check_eq("st_addr_c", 32'(RF_Addr_C), 32'(regs[idx]));
                check_eq("st_wdata", Mem_Wdata, rf[regs[idx]]);
            end
            check_eq("xfer_rf_we", 32'(RF_Load_Write), 32'(ld && ack));
            if (ld && ack) begin
                check_eq("ld_rf_addr", 32'(RF_Addr_Write), 32'(regs[idx]));
                check_eq("ld_rf_data", RF_Bus_Write, Mem_Rdata);
            end
            if (ack) begin
                idx++;
                addr = addr + 32'd4;
                waits = 0;
            end else begin
                waits++;
            end
            @(negedge sysclk);
        end

        if (wb_exp) begin
            scramble_seq_inputs();
            Mem_Ack = 1'($urandom_range(0, 1));
            #1;
            check_eq("wb_req", 32'(Mem_Req), 32'd0);
            check_eq("wb_busy", 32'(Seq_Busy), 32'd1);
            check_eq("wb_we", 32'(RF_Load_Write), 32'd1);
            check_eq("wb_addr", 32'(RF_Addr_Write), 32'(breg));
            check_eq("wb_data", RF_Bus_Write, fin);
            @(negedge sysclk);
        end

        scramble_seq_inputs();
        Mem_Ack = 1'($urandom_range(0, 1));
        #1;
        check_eq("done_pulse", 32'(Seq_Done), 32'd1);
        check_eq("done_busy", 32'(Seq_Busy), 32'd1);
        check_eq("done_req", 32'(Mem_Req), 32'd0);
        check_eq("done_we", 32'(RF_Load_Write), 32'd0);
        @(negedge sysclk);
        Seq_Start = 1'b0;
        Mem_Ack = 1'($urandom_range(0, 1));
        #1;
        check_eq("post_done", 32'(Seq_Done), 32'd0);
        check_eq("post_busy", 32'(Seq_Busy), 32'd0);
        check_eq("post_we", 32'(RF_Load_Write), 32'd0);
        $display("seq ld=%0d up=%0d pre=%0d wb=%0d base=r%0d:%h list=%h n=%0d wb_cycle=%0d",
                 ld, up, pre, wb, breg, base, list, n, wb_exp);
        @(negedge sysclk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(Seq_Busy), 32'd0);
        check_eq({tag, "_done"}, 32'(Seq_Done), 32'd0);
        check_eq({tag, "_req"}, 32'(Mem_Req), 32'd0);
        check_eq({tag, "_write"}, 32'(Mem_Write), 32'd0);
        check_eq({tag, "_addr"}, Mem_Addr, 32'd0);
        check_eq({tag, "_wdata"}, Mem_Wdata, 32'd0);
        check_eq({tag, "_addr_c"}, 32'(RF_Addr_C), 32'd0);
        check_eq({tag, "_rf_addr"}, 32'(RF_Addr_Write), 32'd0);
        check_eq({tag, "_rf_data"}, RF_Bus_Write, 32'd0);
        check_eq({tag, "_rf_we"}, 32'(RF_Load_Write), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int r = 0; r < 16; r++) rf[r] = $urandom;
        reset = 1'b1;
        Seq_Start = 1'b0; Seq_Is_Load = 1'b0; Seq_Up = 1'b0; Seq_Pre = 1'b0; Seq_Writeback = 1'b0;
        Seq_Base_Reg = '0; Seq_Base_Addr = '0; Seq_Reg_List = '0; Mem_Ack = 1'b0; Mem_Rdata = '0;
        repeat (2) @(negedge sysclk);
        #1;
        check_all_zero("reset");
        @(negedge sysclk);
        reset = 1'b0;

        run_seq(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  32'h100, 16'h0013, 1'b1);
        run_seq(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h200, 16'h4003, 1'b1);
        run_seq(1'b1, 1'b1, 1'b1, 1'b0, 4'd5,  32'h800, 16'h00F0, 1'b0);
        run_seq(1'b1, 1'b1, 1'b0, 1'b1, 4'd7,  32'h40,  16'h0000, 1'b1);
        run_seq(1'b1, 1'b1, 1'b0, 1'b1, 4'd2,  32'h500, 16'h0004, 1'b1);
        run_seq(1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  32'h300, 16'h8001, 1'b1);
        run_seq(1'b0, 1'b1, 1'b0, 1'b1, 4'd3,  32'h600, 16'h0018, 1'b0);

        // Abort during the second transfer of a load.
        Seq_Start = 1'b1; Seq_Is_Load = 1'b1; Seq_Up = 1'b1; Seq_Pre = 1'b0; Seq_Writeback = 1'b1;
        Seq_Base_Reg = 4'd1; Seq_Base_Addr = 32'h400; Seq_Reg_List = 16'h00F0; Mem_Ack = 1'b0;
        @(negedge sysclk);
        Seq_Start = 1'b0; Mem_Ack = 1'b1;
        #1;
        check_eq("rst_seq_addr0", Mem_Addr, 32'h400);
        @(negedge sysclk);
        Mem_Ack = 1'b0;
        #1;
        check_eq("rst_seq_addr1", Mem_Addr, 32'h404);
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        check_all_zero("abort");
        @(negedge sysclk);
        reset = 1'b0; Mem_Ack = 1'b1;
        #1;
        check_eq("abort_idle_req", 32'(Mem_Req), 32'd0);
        check_eq("abort_idle_we", 32'(RF_Load_Write), 32'd0);
        $display("seq reset abort during second transfer");
        @(negedge sysclk);
        Mem_Ack = 1'b0;

        for (int t = 0; t < 40; t++) begin
            logic [15:0] lst;
            lst = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom), $urandom & ~32'd3, lst,
                    bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
